// File: rtl/sar_seq_ctrl_pkg.sv
// Shared types and default parameter values for the SAR comparator sequencer.
package sar_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAKE,
    PRE,
    LAT,
    DONE
  } sar_state_t;

  localparam int DEF_N          = 8;
  localparam int DEF_PREAMP_CYC = 2;
  localparam int DEF_LATCH_CYC  = 2;
  localparam int DEF_WARMUP_CYC = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sar_phase_timer.sv
// Loadable down-counter timing one FSM state; expire marks the final cycle of that state.
module sar_phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/sar_seq_ctrl.sv
// SAR comparator sequencer: power-up, pre-amp/latch phase clocks and MSB-first binary search.
// Optional macro SAR_SEQ_CTRL_AUTOPD_EN powers the comparator down after every conversion or abort.
module sar_seq_ctrl
  import sar_seq_ctrl_pkg::*;
#(
  parameter int N          = DEF_N,
  parameter int PREAMP_CYC = DEF_PREAMP_CYC,
  parameter int LATCH_CYC  = DEF_LATCH_CYC,
  parameter int WARMUP_CYC = DEF_WARMUP_CYC
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic         abort,
  input  logic         cmp_out,
  input  logic         cmp_outb,
  output logic         pdn,
  output logic         clk_preamp,
  output logic         clk_latch,
  output logic [N-1:0] dac_code,
  output logic [N-1:0] dout,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int MAXC = max3(WARMUP_CYC, PREAMP_CYC, LATCH_CYC);
  localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int BW   = $clog2(N);
  localparam logic [N-1:0] ONE      = N'(1);
  localparam logic [N-1:0] MSB_CODE = ONE << (N - 1);

  sar_state_t    state;
  logic          go;
  logic [BW-1:0] bit_idx;
  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_expire;
  logic          keep;
  logic          unres;
  logic [N-1:0]  resolved;
  logic [N-1:0]  next_trial;

  sar_phase_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rstn     (rstn),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  // Decision for the current bit and the code of the following trial.
  always_comb begin
    keep              = cmp_out & ~cmp_outb;
    unres             = (cmp_out == cmp_outb);
    resolved          = dac_code;
    resolved[bit_idx] = keep;
    next_trial        = resolved | (ONE << (bit_idx - BW'(1)));
  end

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      IDLE: if (go && !abort) begin
        tmr_load = 1'b1;
        tmr_val  = pdn ? TW'(PREAMP_CYC - 1) : TW'(WARMUP_CYC - 1);
      end
      WAKE: if (tmr_expire) begin
        tmr_load = 1'b1;
        tmr_val  = TW'(PREAMP_CYC - 1);
      end
      PRE: if (tmr_expire) begin
        tmr_load = 1'b1;
        tmr_val  = TW'(LATCH_CYC - 1);
      end
      LAT: if (tmr_expire && bit_idx != '0) begin
        tmr_load = 1'b1;
        tmr_val  = TW'(PREAMP_CYC - 1);
      end
      default: ;
    endcase
  end

  // go holds an accepted start for one cycle so busy and the first state begin one edge later.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      go         <= 1'b0;
      bit_idx    <= '0;
      pdn        <= 1'b0;
      clk_preamp <= 1'b0;
      clk_latch  <= 1'b0;
      dac_code   <= '0;
      dout       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && state != IDLE) begin
        state      <= IDLE;
        clk_preamp <= 1'b0;
        clk_latch  <= 1'b0;
        dac_code   <= '0;
        busy       <= 1'b0;
`ifdef SAR_SEQ_CTRL_AUTOPD_EN
        pdn        <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (abort) begin
              go <= 1'b0;
            end else if (go) begin
              go   <= 1'b0;
              busy <= 1'b1;
              if (pdn) begin
                state      <= PRE;
                clk_preamp <= 1'b1;
                dac_code   <= MSB_CODE;
                bit_idx    <= BW'(N - 1);
              end else begin
                state <= WAKE;
                pdn   <= 1'b1;
              end
            end else if (start) begin
              go  <= 1'b1;
              err <= 1'b0;
            end
          end
          WAKE: if (tmr_expire) begin
            state      <= PRE;
            clk_preamp <= 1'b1;
            dac_code   <= MSB_CODE;
            bit_idx    <= BW'(N - 1);
          end
          PRE: if (tmr_expire) begin
            state      <= LAT;
            clk_preamp <= 1'b0;
            clk_latch  <= 1'b1;
          end
          LAT: if (tmr_expire) begin
            clk_latch <= 1'b0;
            if (unres) err <= 1'b1;
            if (bit_idx == '0) begin
              state    <= DONE;
              dac_code <= resolved;
              dout     <= resolved;
              done     <= 1'b1;
            end else begin
              state      <= PRE;
              clk_preamp <= 1'b1;
              dac_code   <= next_trial;
              bit_idx    <= bit_idx - BW'(1);
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
`ifdef SAR_SEQ_CTRL_AUTOPD_EN
            pdn   <= 1'b0;
`endif
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sar_seq_ctrl.sv
// Self-checking bench for sar_seq_ctrl: offset-based conversion model plus directed scenarios.
module tb_sar_seq_ctrl;

  localparam int N    = 8;
  localparam int PRE  = 2;
  localparam int LATC = 2;
  localparam int WARM = 4;
  localparam int T    = PRE + LATC;
`ifdef SAR_SEQ_CTRL_AUTOPD_EN
  localparam bit AUTOPD = 1'b1;
`else
  localparam bit AUTOPD = 1'b0;
`endif
  localparam int LAT_WARM = 37;
  localparam int LAT2     = AUTOPD ? 37 : 33;
  localparam int PERIOD   = LAT2 + 2;

  logic clk, rstn, start, abort, cmp_out, cmp_outb;
  logic pdn, clk_preamp, clk_latch, busy, done, err;
  logic [N-1:0] dac_code, dout;

  int checks = 0;
  int errors = 0;
  logic chk_en;

  sar_seq_ctrl #(.N(N), .PREAMP_CYC(PRE), .LATCH_CYC(LATC), .WARMUP_CYC(WARM)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .cmp_out(cmp_out), .cmp_outb(cmp_outb),
    .pdn(pdn), .clk_preamp(clk_preamp), .clk_latch(clk_latch),
    .dac_code(dac_code), .dout(dout), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus-side expectations for the conversion about to be requested.
  logic [7:0] vin;
  int         bad_k;
  logic [7:0] t_trial [N];
  logic [7:0] t_res;

  // Model state.
  logic       m_act, m_pdn, m_err;
  int         m_r, m_w, m_bad;
  logic [7:0] m_dac, m_dout, m_res;
  logic [7:0] m_trial [N];

  // Expected outputs for the current cycle.
  logic       e_pdn, e_pre, e_lat, e_busy, e_done, e_err;
  logic [7:0] e_dac, e_dout;
  int         e_k, jj, pp;

  function automatic void calc(input logic [7:0] v, input int bad,
                               output logic [7:0] tr [N], output logic [7:0] res);
    logic [7:0] c;
    c = '0;
    for (int k = N - 1; k >= 0; k--) begin
      tr[k] = c | (8'd1 << k);
      if (k != bad && v >= tr[k]) c = tr[k];
    end
    res = c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Comparator: ideal decision vin >= dac_code, unresolved during the selected trial.
  logic unres_tb, ge;
  assign unres_tb = (e_k >= 0) && (e_k == m_bad);
  assign ge       = (vin >= dac_code);
  assign cmp_out  = unres_tb | ge;
  assign cmp_outb = unres_tb | ~ge;

  always_comb begin
    e_pdn  = m_pdn;
    e_pre  = 1'b0;
    e_lat  = 1'b0;
    e_dac  = m_dac;
    e_dout = m_dout;
    e_busy = 1'b0;
    e_done = 1'b0;
    e_err  = m_err;
    e_k    = -1;
    jj     = 0;
    pp     = 0;
    if (m_act && m_r >= 1) begin
      e_busy = 1'b1;
      e_pdn  = 1'b1;
      e_err  = (m_bad >= 0) && (m_r > m_w + (N - m_bad) * T);
      if (m_r > m_w && m_r <= m_w + N * T) begin
        jj    = (m_r - m_w - 1) / T;
        pp    = (m_r - m_w - 1) % T;
        e_k   = N - 1 - jj;
        e_pre = (pp < PRE);
        e_lat = (pp >= PRE);
        e_dac = m_trial[e_k];
      end else if (m_r == m_w + N * T + 1) begin
        e_done = 1'b1;
        e_dout = m_res;
        e_dac  = m_res;
      end
    end
  end

  // Model advance: offset m_r counts cycles since the edge that accepted start.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_act  <= 1'b0;
      m_r    <= 0;
      m_w    <= 0;
      m_bad  <= -1;
      m_pdn  <= 1'b0;
      m_err  <= 1'b0;
      m_dac  <= '0;
      m_dout <= '0;
      m_res  <= '0;
    end else if (m_act) begin
      if (abort) begin
        m_act <= 1'b0;
        if (m_r >= 1) begin
          m_dac <= '0;
          m_pdn <= !AUTOPD;
          m_err <= e_err;
        end
      end else if (m_r == m_w + N * T + 1) begin
        m_act  <= 1'b0;
        m_dout <= m_res;
        m_dac  <= m_res;
        m_pdn  <= !AUTOPD;
        m_err  <= e_err;
      end else begin
        m_r <= m_r + 1;
      end
    end else if (start && !abort) begin
      m_act   <= 1'b1;
      m_r     <= 0;
      m_w     <= m_pdn ? 0 : WARM;
      m_err   <= 1'b0;
      m_bad   <= bad_k;
      m_res   <= t_res;
      m_trial <= t_trial;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pdn", {31'd0, pdn}, {31'd0, e_pdn});
      chk("clk_preamp", {31'd0, clk_preamp}, {31'd0, e_pre});
      chk("clk_latch", {31'd0, clk_latch}, {31'd0, e_lat});
      chk("dac_code", {24'd0, dac_code}, {24'd0, e_dac});
      chk("dout", {24'd0, dout}, {24'd0, e_dout});
      chk("busy", {31'd0, busy}, {31'd0, e_busy});
      chk("done", {31'd0, done}, {31'd0, e_done});
      chk("err", {31'd0, err}, {31'd0, e_err});
      chk("phase_overlap", {31'd0, clk_preamp & clk_latch}, 32'd0);
    end
  end

  task automatic prep(input logic [7:0] v, input int bad);
    vin   = v;
    bad_k = bad;
    calc(v, bad, t_trial, t_res);
  endtask

  // Called at a negedge in an IDLE cycle; returns at the negedge of the done cycle.
  task automatic do_conv(input logic [7:0] v, input int bad, output int lat);
    prep(v, bad);
    start = 1'b1;
    lat   = -1;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        lat = n;
        break;
      end
    end
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL conv_timeout: no done within 200 cycles for vin %0h", v);
    end
  endtask

  int lat, ndone, r_ab;
  int dc[$];

  initial begin
    start  = 1'b0;
    abort  = 1'b0;
    vin    = '0;
    bad_k  = -1;
    chk_en = 1'b0;
    rstn   = 1'b1;
    prep(8'h00, -1);
    #2 rstn = 1'b0;
    #1 chk_en = 1'b1;

    @(negedge clk);
    chk("rst_pdn", {31'd0, pdn}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_dout", {24'd0, dout}, 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    do_conv(8'hA5, -1, lat);
    chk("lat_cold", lat, LAT_WARM);
    chk("dout_a5", {24'd0, dout}, 32'h0000_00A5);
    chk("err_a5", {31'd0, err}, 32'd0);
    @(negedge clk);

    do_conv(8'h3C, -1, lat);
    chk("lat_second", lat, LAT2);
    chk("dout_3c", {24'd0, dout}, 32'h0000_003C);
    @(negedge clk);

    do_conv(8'hFF, 5, lat);
    chk("dout_unres", {24'd0, dout}, 32'h0000_00DF);
    chk("err_unres", {31'd0, err}, 32'd1);
    @(negedge clk);

    do_conv(8'h81, -1, lat);
    chk("err_cleared", {31'd0, err}, 32'd0);
    chk("dout_81", {24'd0, dout}, 32'h0000_0081);
    @(negedge clk);

    // Abort in the first LAT cycle of trial 3.
    prep(8'h77, -1);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    r_ab = m_w + (N - 1 - 3) * T + PRE + 1;
    repeat (r_ab) @(negedge clk);
    chk("abort_in_lat", {31'd0, clk_latch}, 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_latch", {31'd0, clk_latch}, 32'd0);
    chk("abort_dac", {24'd0, dac_code}, 32'd0);
    chk("abort_dout", {24'd0, dout}, 32'h0000_0081);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_nodone", ndone, 0);

    // abort and start together while idle: start is dropped.
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("abort_start_busy", {31'd0, busy}, 32'd0);
    end

    // Asynchronous reset in the middle of a PRE phase.
    prep(8'h42, -1);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (m_w + 1) @(negedge clk);
    chk("mid_pre", {31'd0, clk_preamp}, 32'd1);
    @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    chk("arst_pdn", {31'd0, pdn}, 32'd0);
    chk("arst_pre", {31'd0, clk_preamp}, 32'd0);
    chk("arst_lat", {31'd0, clk_latch}, 32'd0);
    chk("arst_dac", {24'd0, dac_code}, 32'd0);
    chk("arst_dout", {24'd0, dout}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    do_conv(8'h42, -1, lat);
    chk("lat_after_rst", lat, LAT_WARM);
    chk("dout_42", {24'd0, dout}, 32'h0000_0042);
    @(negedge clk);

    // start held high: a new conversion is accepted in the first IDLE cycle after each done.
    prep(8'h99, -1);
    start = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) dc.push_back(i);
    end
    start = 1'b0;
    chk("held_count", dc.size(), 5);
    if (dc.size() >= 1) chk("held_first", dc[0], LAT2);
    for (int i = 1; i < dc.size(); i++) chk("held_period", dc[i] - dc[i-1], PERIOD);
    chk("held_dout", {24'd0, dout}, 32'h0000_0099);
    repeat (60) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sar_seq_ctrl.md
# sar_seq_ctrl

Sequencer for the SAR ADC comparator path (pre-amp stage 1 → pre-amp stage 2 → sense-amp latch). It powers the comparator up, generates the `clk_preamp`/`clk_latch` phase pair for every bit trial, and samples the latch decision (`cmp_out`/`cmp_outb`). It drives the trial code to the capacitor DAC and runs an N-bit binary search, MSB first. It sits between the conversion-request logic and the analog comparator/DAC models.

## Interface
- `N`, 8: resolution in bits (2..16).
- `PREAMP_CYC`, 2: `clk` cycles `clk_preamp` is high per bit trial (≥1).
- `LATCH_CYC`, 2: `clk` cycles `clk_latch` is high per bit trial (≥1).
- `WARMUP_CYC`, 4: cycles between `pdn` rising and the first trial (≥1).

- `clk`  in  1  system clock.
- `rstn`  in  1  **asynchronous, active-low reset.**
- `start`  in  1  conversion request, sampled on `clk` rising edge.
- `abort`  in  1  synchronous cancel of the conversion in progress.
- `cmp_out`, `cmp_outb`  in  1 each  sense-amp differential decision.
- `pdn`  out  1  comparator enable; 0 = powered down.
- `clk_preamp`  out  1  pre-amp clock to both pre-amp stages.
- `clk_latch`  out  1  sense-amp latch clock.
- `dac_code`  out  N  trial code to the DAC.
- `dout`  out  N  last completed result.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle pulse when `dout` updates.
- `err`  out  1  sticky flag: at least one trial was unresolved. Cleared on the next accepted `start`.

## Operation
- States:
  - `IDLE`
  - `WAKE`
  - `PRE`: `clk_preamp`=1
  - `LAT`: `clk_latch`=1
  - `DONE`
- Transitions:
  - `IDLE` + `start` → `WAKE` if `pdn`=0, else → `PRE`.
  - `WAKE` lasts `WARMUP_CYC` cycles, then → `PRE`. `pdn`=1 from entry into `WAKE`.
  - `PRE` lasts `PREAMP_CYC` cycles → `LAT`.
  - `LAT` lasts `LATCH_CYC` cycles. The decision is sampled on the last `LAT` cycle.
  - After `LAT`: → `PRE` for the next bit, or → `DONE` after bit 0.
  - `DONE` lasts 1 cycle → `IDLE`.
- Bit trial k (k = N-1 down to 0):
  - `dac_code` = committed bits above k, bit k = 1, lower bits = 0.
  - `dac_code` is valid from the first `PRE` cycle of trial k.
- Decision:
  - `cmp_out`=1, `cmp_outb`=0 → keep bit k.
  - `cmp_out`=0, `cmp_outb`=1 → clear bit k.
  - `cmp_out`==`cmp_outb` (unresolved/metastable) → clear bit k and set `err`.
- In `DONE`: `dout` ← final code and `done`=1. `dac_code` holds the final code until the next trial.
- `start` while `busy` is ignored. `start` in the `DONE` cycle is ignored.
- `abort` while `busy`:
  - Next state is `IDLE`. `clk_preamp`/`clk_latch` drop the next cycle.
  - No `done` pulse; `dout` is unchanged; `dac_code` returns to 0.
  - `pdn` follows the Configuration rule.
- `abort` and `start` in the same `IDLE` cycle: `abort` wins, so `start` is dropped.
- `clk_preamp` and `clk_latch` are never high in the same cycle.
- `rstn` low, at any time including mid-conversion, forces these values immediately:
  - `IDLE`, `pdn`=0, `clk_preamp`=0, `clk_latch`=0.
  - `dac_code`=0, `dout`=0, `busy`=0, `done`=0, `err`=0.

## Timing
- All outputs are registered and glitch-free; there are no combinational paths from inputs to outputs.
- Let T_bit = `PREAMP_CYC`+`LATCH_CYC`. `start` is sampled at edge 0.
- Latency from a powered-down comparator: `done` is high in cycle `WARMUP_CYC` + N·T_bit + 1. Defaults give cycle 37.
- Latency with the comparator already powered (no `WAKE`): cycle N·T_bit + 1. Defaults give cycle 33.
- `busy` rises at edge 1 and falls together with the end of `done`.
- A new `start` is accepted one cycle after `done`, i.e. in the first `IDLE` cycle.

## Configuration
- Macro: `SAR_SEQ_CTRL_AUTOPD_EN`.
- Defined: `pdn` drops to 0 on the cycle after `DONE` or after an abort, so every conversion pays the `WAKE` cost.
- Undefined: once `pdn` rises it stays 1 until reset, so `WAKE` occurs only on the first conversion after reset.

## Structure
- Package `sar_seq_ctrl_pkg` holds:
  - The state enum `sar_state_t`.
  - The default parameter constants.
- Sub-module `sar_phase_timer`: a loadable down-counter sized for max(`WARMUP_CYC`, `PREAMP_CYC`, `LATCH_CYC`). It is loaded on each state entry and asserts `expire` on the final cycle of the state. The FSM and bit register live in `sar_seq_ctrl`.

## Test plan
- Defaults, macro undefined, comparator model equivalent to input code 0xA5, one `start` → `done` at cycle 37, `dout`=0xA5, `err`=0. A second `start` → `done` at cycle 33.
- Macro defined, two back-to-back conversions → `pdn` falls after each `DONE`. Both conversions take 37 cycles.
- `cmp_out`=`cmp_outb`=1 forced during trial 5 only, true code 0xFF → `dout`=0xDF, `err`=1. The next `start` clears `err`.
- `abort` in trial 3 `LAT` → `IDLE` next cycle, no `done`, `dout` holds the previous value, phase clocks low.
- `rstn` pulsed low mid-`PRE` → all outputs at reset values asynchronously, before the next `clk` edge. Then a normal conversion completes.
- `start` held high continuously → conversions repeat every `done`+1 cycle. `clk_preamp`&`clk_latch` is never 1.
